// File: rtl/ber_checker_if.sv
// ber_checker_if: sample-side and result-side signals of the BER checker.
// master drives samples and controls; slave is the checker itself.
interface ber_checker_if #(
  parameter int NB_INPUT  = 8,
  parameter int OS_FACTOR = 4,
  parameter int NB_COUNT  = 32
);
  localparam int NB_PHASE = $clog2(OS_FACTOR);

  logic                       i_enable;
  logic signed [NB_INPUT-1:0] i_data;
  logic [NB_PHASE-1:0]        i_phase;
  logic                       i_clear;
  logic                       o_bit;
  logic                       o_valid;
  logic                       o_sync;
  logic [NB_COUNT-1:0]        o_bit_count;
  logic [NB_COUNT-1:0]        o_err_count;

  modport master (
    output i_enable, i_data, i_phase, i_clear,
    input  o_bit, o_valid, o_sync, o_bit_count, o_err_count
  );

  modport slave (
    input  i_enable, i_data, i_phase, i_clear,
    output o_bit, o_valid, o_sync, o_bit_count, o_err_count
  );
endinterface

// File: rtl/ber_checker.sv
// ber_checker: decimates an oversampled FIR output to one sample per symbol,
// slices it on the sign bit and checks the bit stream against a PRBS9
// (x^9 + x^5 + 1) reference that self-synchronises from the received data.
// Once locked, every symbol is counted and every mismatch is an error.
//
// Optional feature: define BER_CHECKER_LOCK_LOSS_EN to drop lock when a
// 128-symbol window holds 32 or more errors. Without it lock is sticky.
module ber_checker #(
  parameter int NB_INPUT  = 8,
  parameter int NBF_INPUT = 7,
  parameter int OS_FACTOR = 4,
  parameter int NB_COUNT  = 32,
  parameter int SYNC_LEN  = 32
) (
  input  logic          clock,
  input  logic          i_reset,
  ber_checker_if.slave  bus
);

  localparam int NB_PHASE = $clog2(OS_FACTOR);
  localparam int RUN_W    = $clog2(SYNC_LEN + 1);
  localparam logic [31:0] NBF_W = NBF_INPUT;

  typedef enum logic [1:0] {
    SEARCH,
    LOAD,
    CHECK,
    LOCKED
  } state_t;

  state_t              state_q, state_d;
  logic [NB_PHASE-1:0] phase_q;
  logic [8:0]          lfsr_q, lfsr_d;
  logic [8:0]          lfsr_shift;
  logic [3:0]          load_cnt_q, load_cnt_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                sample;
  logic                slice;
  logic                pred;
  logic                cnt_inc;
  logic                err_inc;
  logic                bit_q;
  logic                valid_q;
  logic [NB_COUNT-1:0] bit_cnt_q;
  logic [NB_COUNT-1:0] err_cnt_q;
  logic                unused_bits;

`ifdef BER_CHECKER_LOCK_LOSS_EN
  logic [6:0] win_sym_q, win_sym_d;
  logic [7:0] win_err_q, win_err_d;
  logic [7:0] win_err_nx;
`endif

  // Only the sign bit matters to the slicer; fraction bits are don't-care.
  assign unused_bits = ^{bus.i_data[NB_INPUT-2:0], NBF_W[0]};

  assign sample     = bus.i_enable && (phase_q == bus.i_phase);
  assign slice      = bus.i_data[NB_INPUT-1];
  assign pred       = lfsr_q[8] ^ lfsr_q[4];
  assign lfsr_shift = {lfsr_q[7:0], slice};

  // Free-running sample phase counter, frozen while disabled.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q <= '0;
    end else if (bus.i_enable) begin
      phase_q <= phase_q + NB_PHASE'(1);
    end
  end

  // Synchronisation FSM and reference-LFSR state registers.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= SEARCH;
      lfsr_q     <= '0;
      load_cnt_q <= '0;
      run_q      <= '0;
`ifdef BER_CHECKER_LOCK_LOSS_EN
      win_sym_q  <= '0;
      win_err_q  <= '0;
`endif
    end else if (bus.i_enable) begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      load_cnt_q <= load_cnt_d;
      run_q      <= run_d;
`ifdef BER_CHECKER_LOCK_LOSS_EN
      win_sym_q  <= win_sym_d;
      win_err_q  <= win_err_d;
`endif
    end
  end

  // Next-state logic: the SEARCH sample is the first of the nine loaded bits,
  // so lock is reached after 9 + SYNC_LEN clean symbols.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    load_cnt_d = load_cnt_q;
    run_d      = run_q;
    cnt_inc    = 1'b0;
    err_inc    = 1'b0;
`ifdef BER_CHECKER_LOCK_LOSS_EN
    win_sym_d  = win_sym_q;
    win_err_d  = win_err_q;
    win_err_nx = win_err_q;
`endif
    if (sample) begin
      unique case (state_q)
        SEARCH: begin
          lfsr_d     = lfsr_shift;
          load_cnt_d = 4'd1;
          state_d    = LOAD;
        end
        LOAD: begin
          lfsr_d = lfsr_shift;
          if (load_cnt_q == 4'd8) begin
            load_cnt_d = '0;
            run_d      = '0;
            state_d    = (lfsr_shift == '0) ? SEARCH : CHECK;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
        CHECK: begin
          if (slice == pred) begin
            lfsr_d = {lfsr_q[7:0], pred};
            if (run_q == RUN_W'(SYNC_LEN - 1)) begin
              run_d   = '0;
              state_d = LOCKED;
            end else begin
              run_d = run_q + RUN_W'(1);
            end
          end else begin
            run_d   = '0;
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          lfsr_d  = {lfsr_q[7:0], pred};
          cnt_inc = 1'b1;
          err_inc = (slice != pred);
`ifdef BER_CHECKER_LOCK_LOSS_EN
          win_err_nx = win_err_q + {7'd0, err_inc};
          if (win_sym_q == 7'd127) begin
            win_sym_d = '0;
            win_err_d = '0;
            if (win_err_nx >= 8'd32) begin
              state_d = SEARCH;
            end
          end else begin
            win_sym_d = win_sym_q + 7'd1;
            win_err_d = win_err_nx;
          end
`endif
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Saturating bit/error counters; a clear overrides a coincident sample.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (bus.i_enable) begin
      if (bus.i_clear) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
      end else begin
        if (cnt_inc && (bit_cnt_q != '1)) begin
          bit_cnt_q <= bit_cnt_q + NB_COUNT'(1);
        end
        if (err_inc && (err_cnt_q != '1)) begin
          err_cnt_q <= err_cnt_q + NB_COUNT'(1);
        end
      end
    end
  end

  // Sliced-bit output; o_valid is a strobe and never stretches while disabled.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= sample;
      if (sample) begin
        bit_q <= slice;
      end
    end
  end

  assign bus.o_bit       = bit_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_sync      = (state_q == LOCKED);
  assign bus.o_bit_count = bit_cnt_q;
  assign bus.o_err_count = err_cnt_q;

endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 SHALL have parameter NB_INPUT, default 8, input sample width (signed).
REQ-002 SHALL have parameter NBF_INPUT, default 7, input fractional bits.
REQ-003 SHALL have parameter OS_FACTOR, default 4, samples per symbol (power of 2, ≥2).
REQ-004 SHALL have parameter NB_COUNT, default 32, bit/error counter width.
REQ-005 SHALL have parameter SYNC_LEN, default 32, consecutive matches to declare lock.
REQ-006 clock  in  1  system clock, all state on rising edge.
REQ-007 i_reset  in  1  asynchronous, active-low reset (0 = reset).
REQ-008 i_enable  in  1  1 = advance; 0 = freeze all state and outputs.
REQ-009 i_data  in  NB_INPUT  FIR output sample, signed Q(NB_INPUT,NBF_INPUT).
REQ-010 i_phase  in  log2(OS_FACTOR)  sampling phase selector.
REQ-011 i_clear  in  1  synchronous clear of counters.
REQ-012 o_bit  out  1  last sliced bit.
REQ-013 o_valid  out  1  one-cycle strobe per sliced bit.
REQ-014 o_sync  out  1  1 = PRBS lock.
REQ-015 o_bit_count  out  NB_COUNT  bits compared while locked.
REQ-016 o_err_count  out  NB_COUNT  mismatches while locked.

Function
REQ-017 Phase counter SHALL count 0..OS_FACTOR-1 on each enabled cycle, wrapping to 0.
REQ-018 Sample SHALL be taken on enabled cycles where phase counter equals i_phase; i_phase changes SHALL apply next cycle, no forced resync.
REQ-019 Slicer SHALL output bit = sign bit of i_data (negative → 1, zero/positive → 0).
REQ-020 o_bit/o_valid SHALL be registered, asserting one cycle after the sample cycle; o_valid high exactly one cycle.
REQ-021 Reference SHALL be PRBS9, x^9+x^5+1, 9-bit local LFSR.
REQ-022 FSM states SHALL be SEARCH, LOAD, CHECK, LOCKED.
REQ-023 SEARCH → LOAD on next sample; LOAD shifts 9 sliced bits into LFSR.
REQ-024 After 9 loaded bits: all-zero LFSR → SEARCH (restart load); else → CHECK.
REQ-025 CHECK: each sample compares bit to LFSR prediction; match increments run counter; mismatch → SEARCH, run cleared.
REQ-026 CHECK → LOCKED when run counter reaches SYNC_LEN; o_sync=1 the cycle after that sample.
REQ-027 LOCKED: each sample increments o_bit_count, mismatch also increments o_err_count; LFSR free-runs (no reload from data).
REQ-028 Counters SHALL saturate at 2^NB_COUNT-1, never wrap.
REQ-029 i_clear SHALL zero both counters next cycle; FSM/o_sync unaffected; if coincident with a sample, clear wins and sample is not counted.
REQ-030 Counters SHALL only change in LOCKED.

Reset
REQ-031 While i_reset=0: FSM=SEARCH, phase counter, LFSR, run counter, window counters = 0; o_bit, o_valid, o_sync, o_bit_count, o_err_count = 0.
REQ-032 Reset asserted mid-operation SHALL take effect immediately regardless of i_enable; release resumes from SEARCH.

Configuration
REQ-033 Macro BER_CHECKER_LOCK_LOSS_EN defined: in LOCKED, non-overlapping 128-symbol windows count errors; ≥32 errors in a window → SEARCH, o_sync=0 the cycle after the window's last sample; counters retain values.
REQ-034 Macro undefined: LOCKED is sticky until reset; no window logic synthesized.

Verification
REQ-035 i_reset=0 mid-stream with random i_data → all outputs 0 asynchronously, before next clock edge.
REQ-036 Clean PRBS9, bit 0→8'h73, bit 1→8'h8D, each held 4 cycles, i_phase=0 → o_sync=1 after 41 symbols; o_err_count=0, o_bit_count +1 per symbol.
REQ-037 After lock, invert one symbol (8'h73↔8'h8D) → o_err_count=1 exactly, o_sync stays 1.
REQ-038 After lock, i_clear=1 one cycle coincident with a sample → both counters 0, o_sync=1, that sample not counted.
REQ-039 i_enable=0 for 100 cycles mid-lock → counters, o_sync, phase frozen; resume with zero new errors.
REQ-040 After lock, constant 8'h73 for 256 symbols → with BER_CHECKER_LOCK_LOSS_EN o_sync drops at first 128-symbol window end; without, o_sync stays 1, errors keep counting.
